// File: rtl/pcie_axis_traffic_engine_if.sv
// TX/RX AXI-Stream bundle between the traffic engine and the PCIe AXI bridge.
// The master modport is the engine side, the slave modport is the bridge side.
interface pcie_axis_traffic_engine_if;
    logic [31:0] s_axis_tx_tdata;
    logic [3:0]  s_axis_tx_tkeep;
    logic [3:0]  s_axis_tx_tuser;
    logic        s_axis_tx_tlast;
    logic        s_axis_tx_tvalid;
    logic        s_axis_tx_tready;
    logic [31:0] m_axis_rx_tdata;
    logic [3:0]  m_axis_rx_tkeep;
    logic        m_axis_rx_tlast;
    logic        m_axis_rx_tvalid;
    logic        m_axis_rx_tready;
    logic        rx_np_ok;

    modport master (
        output s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser,
        output s_axis_tx_tlast, s_axis_tx_tvalid,
        input  s_axis_tx_tready,
        input  m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid,
        output m_axis_rx_tready, rx_np_ok
    );

    modport slave (
        input  s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser,
        input  s_axis_tx_tlast, s_axis_tx_tvalid,
        output s_axis_tx_tready,
        output m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid,
        input  m_axis_rx_tready, rx_np_ok
    );
endinterface

// File: rtl/pcie_axis_traffic_engine.sv
// PCIe AXI bridge traffic engine: TX sources bursts of incrementing-word packets,
// RX checks incoming packets against the same pattern and the per-function size.
module pcie_axis_traffic_engine #(
    parameter int CONTROL_PACKET_SIZE = 128,
    parameter int DATA_PACKET_SIZE    = 512,
    parameter int COUNT_WIDTH         = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        user_lnk_up,
    input  logic [2:0]                  cfg_function_number,
    input  logic                        i_tx_start,
    input  logic [15:0]                 i_tx_packet_count,
    input  logic                        i_clear,
    pcie_axis_traffic_engine_if.master  axis,
    output logic                        o_tx_busy,
    output logic                        o_tx_done,
    output logic                        o_tx_abort,
    output logic [15:0]                 o_rx_packet_count,
    output logic [15:0]                 o_rx_error_count,
    output logic                        o_rx_error
);
    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO  = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CTRL_SIZE = COUNT_WIDTH'(CONTROL_PACKET_SIZE);
    localparam logic [COUNT_WIDTH-1:0] DATA_SIZE = COUNT_WIDTH'(DATA_PACKET_SIZE);

    // Packet length in words for a PCIe function; unused functions have no packets.
    function automatic logic [COUNT_WIDTH-1:0] size_of(input logic [2:0] fn);
        logic [COUNT_WIDTH-1:0] sz;
        case (fn)
            3'd0:    sz = CTRL_SIZE;
            3'd1:    sz = DATA_SIZE;
            default: sz = CNT_ZERO;
        endcase
        return sz;
    endfunction

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_GAP  = 2'd2,
        TX_DONE = 2'd3
    } tx_state_t;

    tx_state_t              tx_state_r, tx_state_s;
    logic [COUNT_WIDTH-1:0] tx_idx_r, tx_idx_s;
    logic [COUNT_WIDTH-1:0] tx_size_r, tx_size_s;
    logic [15:0]            tx_pkts_r, tx_pkts_s;
    logic                   tx_valid_r, tx_valid_s;
    logic                   tx_last_r, tx_last_s;
    logic                   tx_busy_r, tx_busy_s;
    logic                   tx_done_r, tx_done_s;
    logic                   tx_abort_r, tx_abort_s;
    logic [COUNT_WIDTH-1:0] start_size_s;
    logic                   tx_xfer_s;

    logic                   rx_rdy_r;
    logic [COUNT_WIDTH-1:0] rx_idx_r, rx_idx_s;
    logic [COUNT_WIDTH-1:0] rx_size_r, rx_size_s;
    logic [31:0]            rx_exp_r, rx_exp_s;
    logic [15:0]            rx_pkt_r, rx_pkt_s;
    logic [15:0]            rx_err_cnt_r, rx_err_cnt_s;
    logic                   rx_err_r, rx_err_s;
    logic                   rx_beat_s;
    logic [COUNT_WIDTH-1:0] rx_cur_size_s;
    logic                   rx_at_end_s;
    logic                   rx_bad_s;

    assign start_size_s = size_of(cfg_function_number);
    assign tx_xfer_s    = tx_valid_r & axis.s_axis_tx_tready;

    // TX next-state and next-output logic; link loss in SEND/GAP aborts the burst.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_idx_s   = tx_idx_r;
        tx_size_s  = tx_size_r;
        tx_pkts_s  = tx_pkts_r;
        tx_valid_s = tx_valid_r;
        tx_last_s  = tx_last_r;
        tx_abort_s = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                tx_valid_s = 1'b0;
                tx_last_s  = 1'b0;
                if (i_tx_start && user_lnk_up) begin
                    tx_size_s = start_size_s;
                    tx_pkts_s = i_tx_packet_count;
                    tx_idx_s  = CNT_ZERO;
                    if ((start_size_s == CNT_ZERO) || (i_tx_packet_count == 16'd0)) begin
                        tx_state_s = TX_DONE;
                    end else begin
                        tx_state_s = TX_SEND;
                        tx_valid_s = 1'b1;
                        tx_last_s  = (start_size_s == CNT_ONE);
                    end
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_SEND: begin
                if (!user_lnk_up) begin
                    tx_state_s = TX_IDLE;
                    tx_valid_s = 1'b0;
                    tx_last_s  = 1'b0;
                    tx_idx_s   = CNT_ZERO;
                    tx_abort_s = 1'b1;
                end else if (tx_xfer_s) begin
                    if (tx_last_r) begin
                        tx_valid_s = 1'b0;
                        tx_last_s  = 1'b0;
                        tx_idx_s   = CNT_ZERO;
                        tx_pkts_s  = tx_pkts_r - 16'd1;
                        if (tx_pkts_r > 16'd1) begin
                            tx_state_s = TX_GAP;
                        end else begin
                            tx_state_s = TX_DONE;
                        end
                    end else begin
                        tx_idx_s  = tx_idx_r + CNT_ONE;
                        tx_last_s = ((tx_idx_r + CNT_ONE) == (tx_size_r - CNT_ONE));
                    end
                end else begin
                    tx_state_s = TX_SEND;
                end
            end
            TX_GAP: begin
                if (!user_lnk_up) begin
                    tx_state_s = TX_IDLE;
                    tx_valid_s = 1'b0;
                    tx_last_s  = 1'b0;
                    tx_abort_s = 1'b1;
                end else begin
                    tx_state_s = TX_SEND;
                    tx_idx_s   = CNT_ZERO;
                    tx_valid_s = 1'b1;
                    tx_last_s  = (tx_size_r == CNT_ONE);
                end
            end
            TX_DONE: begin
                tx_state_s = TX_IDLE;
            end
            default: begin
                tx_state_s = TX_IDLE;
                tx_valid_s = 1'b0;
                tx_last_s  = 1'b0;
            end
        endcase
        tx_busy_s = (tx_state_s != TX_IDLE);
        tx_done_s = (tx_state_s == TX_DONE);
    end

    assign rx_beat_s     = axis.m_axis_rx_tvalid & rx_rdy_r;
    assign rx_cur_size_s = (rx_idx_r == CNT_ZERO) ? size_of(cfg_function_number) : rx_size_r;
    assign rx_at_end_s   = (rx_idx_r == (rx_cur_size_s - CNT_ONE));
    assign rx_bad_s      = (axis.m_axis_rx_tdata != rx_exp_r) ||
                           (axis.m_axis_rx_tkeep != 4'hF) ||
                           (axis.m_axis_rx_tlast && !rx_at_end_s) ||
                           (!axis.m_axis_rx_tlast && rx_at_end_s) ||
                           (rx_cur_size_s == CNT_ZERO);

    // RX checker: tracks position/expected word, counts packets and bad beats.
    always_comb begin
        rx_idx_s     = rx_idx_r;
        rx_size_s    = rx_size_r;
        rx_exp_s     = rx_exp_r;
        rx_pkt_s     = rx_pkt_r;
        rx_err_cnt_s = rx_err_cnt_r;
        rx_err_s     = rx_err_r;
        if (!user_lnk_up) begin
            rx_idx_s = CNT_ZERO;
            rx_exp_s = 32'd0;
        end else if (rx_beat_s) begin
            rx_size_s = rx_cur_size_s;
            if (axis.m_axis_rx_tlast) begin
                rx_idx_s = CNT_ZERO;
                rx_exp_s = 32'd0;
                if (rx_pkt_r != 16'hFFFF) begin
                    rx_pkt_s = rx_pkt_r + 16'd1;
                end else begin
                    rx_pkt_s = rx_pkt_r;
                end
            end else begin
                rx_idx_s = rx_idx_r + CNT_ONE;
                rx_exp_s = axis.m_axis_rx_tdata + 32'd1;
            end
            if (rx_bad_s) begin
                rx_err_s = 1'b1;
                if (rx_err_cnt_r != 16'hFFFF) begin
                    rx_err_cnt_s = rx_err_cnt_r + 16'd1;
                end else begin
                    rx_err_cnt_s = rx_err_cnt_r;
                end
            end else begin
                rx_err_s = rx_err_r;
            end
        end else begin
            rx_idx_s = rx_idx_r;
        end
        // Clear overrides any status update from a beat in the same cycle.
        if (i_clear) begin
            rx_pkt_s     = 16'd0;
            rx_err_cnt_s = 16'd0;
            rx_err_s     = 1'b0;
        end else begin
            rx_err_s = rx_err_s;
        end
    end

    // State and output registers for both halves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r   <= TX_IDLE;
            tx_idx_r     <= CNT_ZERO;
            tx_size_r    <= CNT_ZERO;
            tx_pkts_r    <= 16'd0;
            tx_valid_r   <= 1'b0;
            tx_last_r    <= 1'b0;
            tx_busy_r    <= 1'b0;
            tx_done_r    <= 1'b0;
            tx_abort_r   <= 1'b0;
            rx_rdy_r     <= 1'b0;
            rx_idx_r     <= CNT_ZERO;
            rx_size_r    <= CNT_ZERO;
            rx_exp_r     <= 32'd0;
            rx_pkt_r     <= 16'd0;
            rx_err_cnt_r <= 16'd0;
            rx_err_r     <= 1'b0;
        end else begin
            tx_state_r   <= tx_state_s;
            tx_idx_r     <= tx_idx_s;
            tx_size_r    <= tx_size_s;
            tx_pkts_r    <= tx_pkts_s;
            tx_valid_r   <= tx_valid_s;
            tx_last_r    <= tx_last_s;
            tx_busy_r    <= tx_busy_s;
            tx_done_r    <= tx_done_s;
            tx_abort_r   <= tx_abort_s;
            rx_rdy_r     <= user_lnk_up;
            rx_idx_r     <= rx_idx_s;
            rx_size_r    <= rx_size_s;
            rx_exp_r     <= rx_exp_s;
            rx_pkt_r     <= rx_pkt_s;
            rx_err_cnt_r <= rx_err_cnt_s;
            rx_err_r     <= rx_err_s;
        end
    end

    assign axis.s_axis_tx_tdata  = 32'(tx_idx_r);
    assign axis.s_axis_tx_tkeep  = 4'hF;
    assign axis.s_axis_tx_tuser  = 4'h0;
    assign axis.s_axis_tx_tlast  = tx_last_r;
    assign axis.s_axis_tx_tvalid = tx_valid_r;
    assign axis.m_axis_rx_tready = rx_rdy_r;
    assign axis.rx_np_ok         = rx_rdy_r;
    assign o_tx_busy             = tx_busy_r;
    assign o_tx_done             = tx_done_r;
    assign o_tx_abort            = tx_abort_r;
    assign o_rx_packet_count     = rx_pkt_r;
    assign o_rx_error_count      = rx_err_cnt_r;
    assign o_rx_error            = rx_err_r;
endmodule

// File: tb/tb_pcie_axis_traffic_engine.sv
// Directed bench for the PCIe AXI traffic engine: TX bursts, stalls, gaps,
// link-loss abort, zero-size functions, RX pattern checking and clear.
module tb_pcie_axis_traffic_engine;
    logic        clk;
    logic        rst_n;
    logic        user_lnk_up;
    logic [2:0]  cfg_function_number;
    logic        i_tx_start;
    logic [15:0] i_tx_packet_count;
    logic        i_clear;
    logic        o_tx_busy;
    logic        o_tx_done;
    logic        o_tx_abort;
    logic [15:0] o_rx_packet_count;
    logic [15:0] o_rx_error_count;
    logic        o_rx_error;
    int          total;
    int          bad;

    pcie_axis_traffic_engine_if bus ();

    pcie_axis_traffic_engine dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .user_lnk_up         (user_lnk_up),
        .cfg_function_number (cfg_function_number),
        .i_tx_start          (i_tx_start),
        .i_tx_packet_count   (i_tx_packet_count),
        .i_clear             (i_clear),
        .axis                (bus),
        .o_tx_busy           (o_tx_busy),
        .o_tx_done           (o_tx_done),
        .o_tx_abort          (o_tx_abort),
        .o_rx_packet_count   (o_rx_packet_count),
        .o_rx_error_count    (o_rx_error_count),
        .o_rx_error          (o_rx_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst_n = 1'b0; user_lnk_up = 1'b0; cfg_function_number = 3'd0;
        i_tx_start = 1'b0; i_tx_packet_count = 16'd0; i_clear = 1'b0;
        bus.s_axis_tx_tready = 1'b0; bus.m_axis_rx_tvalid = 1'b0;
        bus.m_axis_rx_tdata = 32'd0; bus.m_axis_rx_tkeep = 4'hF; bus.m_axis_rx_tlast = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.s_axis_tx_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%0b want=0", bus.s_axis_tx_tvalid); end
        total++; if (bus.s_axis_tx_tkeep !== 4'hF) begin bad++; $display("FAIL reset_tkeep got=%0h want=f", bus.s_axis_tx_tkeep); end
        total++; if (bus.s_axis_tx_tdata !== 32'd0) begin bad++; $display("FAIL reset_tdata got=%0h want=0", bus.s_axis_tx_tdata); end
        total++; if (o_tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", o_tx_busy); end
        total++; if (o_tx_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", o_tx_done); end
        total++; if (o_rx_packet_count !== 16'd0) begin bad++; $display("FAIL reset_rx_pkt got=%0d want=0", o_rx_packet_count); end
        total++; if (o_rx_error_count !== 16'd0) begin bad++; $display("FAIL reset_rx_err_cnt got=%0d want=0", o_rx_error_count); end
        total++; if (o_rx_error !== 1'b0) begin bad++; $display("FAIL reset_rx_error got=%0b want=0", o_rx_error); end
        total++; if (bus.m_axis_rx_tready !== 1'b0) begin bad++; $display("FAIL reset_rx_tready got=%0b want=0", bus.m_axis_rx_tready); end
        rst_n = 1'b1; user_lnk_up = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.rx_np_ok !== 1'b1) begin bad++; $display("FAIL lnk_rx_np_ok got=%0b want=1", bus.rx_np_ok); end
    endtask

    // Burst of pkts packets of size words; tready high one cycle in every period.
    task automatic test_tx_burst(input logic [2:0] fn, input int pkts, input int size, input int period);
        int beats = 0, pkt_beat = 0, pkts_seen = 0, done_n = 0, after = 0;
        int data_bad = 0, last_bad = 0, stall_bad = 0, gap_bad = 0, post_bad = 0, busy_bad = 0;
        int expect_gap = 0;
        logic prev_valid = 1'b0, prev_xfer = 1'b0, tr;
        logic [31:0] prev_data = 32'd0;
        @(negedge clk);
        cfg_function_number = fn; i_tx_packet_count = 16'(pkts); i_tx_start = 1'b1;
        @(negedge clk);
        i_tx_start = 1'b0;
        for (int c = 0; c < 20000 && after < 4; c++) begin
            tr = ((c % period) == 0);
            bus.s_axis_tx_tready = tr;
            if (expect_gap == 1) begin
                if (bus.s_axis_tx_tvalid !== 1'b0) gap_bad++;
                expect_gap = 2;
            end else if (expect_gap == 2) begin
                if (bus.s_axis_tx_tvalid !== 1'b1 || bus.s_axis_tx_tdata !== 32'd0) gap_bad++;
                expect_gap = 0;
            end else begin
                expect_gap = 0;
            end
            if (prev_valid && !prev_xfer && (bus.s_axis_tx_tvalid !== 1'b1 || bus.s_axis_tx_tdata !== prev_data)) stall_bad++;
            if (bus.s_axis_tx_tvalid === 1'b1 && tr) begin
                if (bus.s_axis_tx_tdata !== 32'(pkt_beat)) data_bad++;
                if (bus.s_axis_tx_tlast !== (pkt_beat == size - 1)) last_bad++;
                beats++;
                if (pkt_beat == size - 1) begin
                    pkt_beat = 0; pkts_seen++;
                    if (pkts_seen < pkts) expect_gap = 1;
                end else begin
                    pkt_beat++;
                end
            end
            if (done_n == 0 && o_tx_busy !== 1'b1) busy_bad++;
            if (o_tx_done === 1'b1) done_n++;
            if (done_n > 0) begin
                if (bus.s_axis_tx_tvalid !== 1'b0) post_bad++;
                after++;
            end
            prev_valid = (bus.s_axis_tx_tvalid === 1'b1);
            prev_xfer = prev_valid && tr;
            prev_data = bus.s_axis_tx_tdata;
            @(negedge clk);
        end
        bus.s_axis_tx_tready = 1'b1;
        total++; if (beats != size * pkts) begin bad++; $display("FAIL tx_beats fn=%0d got=%0d want=%0d", fn, beats, size * pkts); end
        total++; if (data_bad != 0) begin bad++; $display("FAIL tx_data fn=%0d bad_beats=%0d want=0", fn, data_bad); end
        total++; if (last_bad != 0) begin bad++; $display("FAIL tx_tlast fn=%0d bad_beats=%0d want=0", fn, last_bad); end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL tx_stall_hold fn=%0d bad=%0d want=0", fn, stall_bad); end
        total++; if (gap_bad != 0) begin bad++; $display("FAIL tx_gap fn=%0d bad=%0d want=0", fn, gap_bad); end
        total++; if (done_n != 1) begin bad++; $display("FAIL tx_done_pulses fn=%0d got=%0d want=1", fn, done_n); end
        total++; if (post_bad != 0) begin bad++; $display("FAIL tx_idle_after_done fn=%0d bad=%0d want=0", fn, post_bad); end
        total++; if (busy_bad != 0) begin bad++; $display("FAIL tx_busy_during fn=%0d bad=%0d want=0", fn, busy_bad); end
        total++; if (o_tx_busy !== 1'b0) begin bad++; $display("FAIL tx_busy_end fn=%0d got=%0b want=0", fn, o_tx_busy); end
    endtask

    // Zero-size function or zero packet count: straight to DONE, no beats.
    task automatic test_tx_empty(input logic [2:0] fn, input logic [15:0] cnt);
        @(negedge clk);
        cfg_function_number = fn; i_tx_packet_count = cnt; i_tx_start = 1'b1;
        @(negedge clk);
        i_tx_start = 1'b0;
        total++; if (o_tx_done !== 1'b1) begin bad++; $display("FAIL empty_done fn=%0d got=%0b want=1", fn, o_tx_done); end
        total++; if (o_tx_busy !== 1'b1) begin bad++; $display("FAIL empty_busy fn=%0d got=%0b want=1", fn, o_tx_busy); end
        total++; if (bus.s_axis_tx_tvalid !== 1'b0) begin bad++; $display("FAIL empty_tvalid fn=%0d got=%0b want=0", fn, bus.s_axis_tx_tvalid); end
        @(negedge clk);
        total++; if (o_tx_done !== 1'b0) begin bad++; $display("FAIL empty_done_end fn=%0d got=%0b want=0", fn, o_tx_done); end
        total++; if (o_tx_busy !== 1'b0 || bus.s_axis_tx_tvalid !== 1'b0) begin bad++; $display("FAIL empty_idle fn=%0d busy=%0b tvalid=%0b want=0/0", fn, o_tx_busy, bus.s_axis_tx_tvalid); end
    endtask

    // Drives n back-to-back RX beats of 0..n-1; one word may be replaced.
    task automatic rx_send(input int n, input int bad_idx, input logic [31:0] bad_val, input int last_idx, input logic with_clear);
        for (int i = 0; i < n; i++) begin
            bus.m_axis_rx_tvalid = 1'b1;
            bus.m_axis_rx_tdata = (i == bad_idx) ? bad_val : 32'(i);
            bus.m_axis_rx_tkeep = 4'hF;
            bus.m_axis_rx_tlast = (i == last_idx);
            i_clear = with_clear;
            @(negedge clk);
        end
        bus.m_axis_rx_tvalid = 1'b0; bus.m_axis_rx_tlast = 1'b0; i_clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rx_clean();
        cfg_function_number = 3'd0;
        total++; if (bus.m_axis_rx_tready !== 1'b1) begin bad++; $display("FAIL rx_tready got=%0b want=1", bus.m_axis_rx_tready); end
        rx_send(128, -1, 32'd0, 127, 1'b0);
        rx_send(128, -1, 32'd0, 127, 1'b0);
        total++; if (o_rx_packet_count !== 16'd2) begin bad++; $display("FAIL rx_clean_pkt got=%0d want=2", o_rx_packet_count); end
        total++; if (o_rx_error_count !== 16'd0) begin bad++; $display("FAIL rx_clean_err_cnt got=%0d want=0", o_rx_error_count); end
        total++; if (o_rx_error !== 1'b0) begin bad++; $display("FAIL rx_clean_error got=%0b want=0", o_rx_error); end
    endtask

    task automatic test_rx_errors();
        i_clear = 1'b1; @(negedge clk); i_clear = 1'b0;
        total++; if (o_rx_packet_count !== 16'd0) begin bad++; $display("FAIL rx_pre_clear got=%0d want=0", o_rx_packet_count); end
        // Word 5 = 99 flags beat 5; expected then resyncs to 100, so beat 6 flags too.
        rx_send(128, 5, 32'd99, 127, 1'b0);
        total++; if (o_rx_error_count !== 16'd2) begin bad++; $display("FAIL rx_bad_word_cnt got=%0d want=2", o_rx_error_count); end
        total++; if (o_rx_packet_count !== 16'd1) begin bad++; $display("FAIL rx_bad_word_pkt got=%0d want=1", o_rx_packet_count); end
        // Early tlast at index 63 of a 128-word packet: one more error.
        rx_send(64, -1, 32'd0, 63, 1'b0);
        total++; if (o_rx_error_count !== 16'd3) begin bad++; $display("FAIL rx_early_last_cnt got=%0d want=3", o_rx_error_count); end
        total++; if (o_rx_packet_count !== 16'd2) begin bad++; $display("FAIL rx_early_last_pkt got=%0d want=2", o_rx_packet_count); end
        total++; if (o_rx_error !== 1'b1) begin bad++; $display("FAIL rx_sticky_error got=%0b want=1", o_rx_error); end
        i_clear = 1'b1; @(negedge clk); i_clear = 1'b0;
        total++; if (o_rx_packet_count !== 16'd0 || o_rx_error_count !== 16'd0 || o_rx_error !== 1'b0) begin
            bad++; $display("FAIL rx_clear got=%0d/%0d/%0b want=0/0/0", o_rx_packet_count, o_rx_error_count, o_rx_error); end
        // Erroneous single-beat packet arriving together with clear: clear wins.
        rx_send(1, -1, 32'd0, 0, 1'b1);
        total++; if (o_rx_packet_count !== 16'd0 || o_rx_error_count !== 16'd0 || o_rx_error !== 1'b0) begin
            bad++; $display("FAIL rx_clear_vs_beat got=%0d/%0d/%0b want=0/0/0", o_rx_packet_count, o_rx_error_count, o_rx_error); end
    endtask

    task automatic test_rx_size0();
        cfg_function_number = 3'd3;
        rx_send(1, -1, 32'd0, 0, 1'b0);
        total++; if (o_rx_error_count !== 16'd1) begin bad++; $display("FAIL rx_size0_err_cnt got=%0d want=1", o_rx_error_count); end
        total++; if (o_rx_packet_count !== 16'd1) begin bad++; $display("FAIL rx_size0_pkt got=%0d want=1", o_rx_packet_count); end
        total++; if (o_rx_error !== 1'b1) begin bad++; $display("FAIL rx_size0_error got=%0b want=1", o_rx_error); end
        cfg_function_number = 3'd0;
    endtask

    task automatic test_tx_abort();
        int n = 0;
        bus.s_axis_tx_tready = 1'b1;
        cfg_function_number = 3'd1; i_tx_packet_count = 16'd2; i_tx_start = 1'b1;
        @(negedge clk);
        i_tx_start = 1'b0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            if (bus.s_axis_tx_tvalid === 1'b1) n++;
            @(negedge clk);
        end
        total++; if (bus.s_axis_tx_tdata !== 32'd10 || bus.s_axis_tx_tvalid !== 1'b1) begin
            bad++; $display("FAIL abort_pre_data got=%0d valid=%0b want=10/1", bus.s_axis_tx_tdata, bus.s_axis_tx_tvalid); end
        user_lnk_up = 1'b0; bus.s_axis_tx_tready = 1'b0;
        @(negedge clk);
        total++; if (bus.s_axis_tx_tvalid !== 1'b0 || bus.s_axis_tx_tlast !== 1'b0) begin
            bad++; $display("FAIL abort_tvalid got=%0b/%0b want=0/0", bus.s_axis_tx_tvalid, bus.s_axis_tx_tlast); end
        total++; if (o_tx_abort !== 1'b1) begin bad++; $display("FAIL abort_pulse got=%0b want=1", o_tx_abort); end
        total++; if (o_tx_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", o_tx_busy); end
        total++; if (o_tx_done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%0b want=0", o_tx_done); end
        total++; if (bus.m_axis_rx_tready !== 1'b0 || bus.rx_np_ok !== 1'b0) begin
            bad++; $display("FAIL abort_rx_tready got=%0b/%0b want=0/0", bus.m_axis_rx_tready, bus.rx_np_ok); end
        i_tx_start = 1'b1;
        @(negedge clk);
        i_tx_start = 1'b0;
        total++; if (o_tx_abort !== 1'b0) begin bad++; $display("FAIL abort_pulse_end got=%0b want=0", o_tx_abort); end
        @(negedge clk);
        total++; if (o_tx_busy !== 1'b0 || bus.s_axis_tx_tvalid !== 1'b0) begin
            bad++; $display("FAIL start_link_down busy=%0b tvalid=%0b want=0/0", o_tx_busy, bus.s_axis_tx_tvalid); end
        user_lnk_up = 1'b1; bus.s_axis_tx_tready = 1'b1;
        repeat (2) @(negedge clk);
        user_lnk_up = 1'b0; i_tx_start = 1'b1;
        @(negedge clk);
        i_tx_start = 1'b0;
        total++; if (o_tx_busy !== 1'b0) begin bad++; $display("FAIL start_with_drop busy got=%0b want=0", o_tx_busy); end
        user_lnk_up = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_async_reset();
        bus.s_axis_tx_tready = 1'b0;
        cfg_function_number = 3'd1; i_tx_packet_count = 16'd1; i_tx_start = 1'b1;
        @(negedge clk);
        i_tx_start = 1'b0;
        @(negedge clk);
        total++; if (o_tx_busy !== 1'b1 || bus.s_axis_tx_tvalid !== 1'b1) begin
            bad++; $display("FAIL arst_pre busy=%0b tvalid=%0b want=1/1", o_tx_busy, bus.s_axis_tx_tvalid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.s_axis_tx_tvalid !== 1'b0 || o_tx_busy !== 1'b0) begin
            bad++; $display("FAIL arst_tx tvalid=%0b busy=%0b want=0/0", bus.s_axis_tx_tvalid, o_tx_busy); end
        total++; if (o_rx_packet_count !== 16'd0 || o_rx_error_count !== 16'd0 || o_rx_error !== 1'b0) begin
            bad++; $display("FAIL arst_rx got=%0d/%0d/%0b want=0/0/0", o_rx_packet_count, o_rx_error_count, o_rx_error); end
        total++; if (bus.m_axis_rx_tready !== 1'b0) begin bad++; $display("FAIL arst_rx_tready got=%0b want=0", bus.m_axis_rx_tready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_tx_burst(3'd0, 1, 128, 1);
        test_tx_burst(3'd1, 3, 512, 3);
        test_tx_empty(3'd3, 16'd4);
        test_tx_empty(3'd0, 16'd0);
        test_rx_clean();
        test_rx_errors();
        test_rx_size0();
        test_tx_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
